// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit MIPS datapath: sequences fetch/decode/execute/memory/writeback
// over a shared memory, stretches memory states on mem_ready, counts retired instructions, halts on timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       opcode,
  input  logic [3:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             sign_or_zero,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTYPE  = 4'd6,  S_RWB    = 4'd7,
    S_SLI    = 4'd8,  S_ADDI   = 4'd9,  S_IWB    = 4'd10, S_BRANCH = 4'd11,
    S_JUMP   = 4'd12, S_JAL    = 4'd13, S_JR     = 4'd14, S_HALT   = 4'd15
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_wait;

  // The beq compare is resolved in the datapath through pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    bus_err_d     = bus_err_q;
    cnt_d         = cnt_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    sign_or_zero  = 1'b1;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 2'b11;
        case (opcode)
          3'b000:         state_d = (funct == 4'b1000) ? S_JR : S_RTYPE;
          3'b001:         state_d = S_SLI;
          3'b010:         state_d = S_JUMP;
          3'b011:         state_d = S_JAL;
          3'b100, 3'b101: state_d = S_MEMADR;
          3'b110:         state_d = S_BRANCH;
          default:        state_d = S_ADDI;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = (opcode == 3'b100) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPE: begin
        alu_src_a = 1'b1;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_SLI: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = 2'b10;
        sign_or_zero = 1'b0;
        state_d      = S_IWB;
      end
      S_ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // The TIMEOUT-th consecutive wait cycle is fatal; a ready on that cycle still succeeds.
    mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) && !mem_ready;
    if (mem_wait) begin
      if (wait_q == WC_W'(TIMEOUT - 1)) begin
        bus_err_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_HALT))
      cnt_d = cnt_q + 1'b1;
  end

  assign bus_err     = bus_err_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule
